decim_avg_iq_core: RTL and testbench

- Decimating counterpart to the quadratic I/Q interpolator core.
- Reads paired I/Q samples from input FIFOs and averages each block of D = 2^log2D consecutive samples per lane.
- Writes one averaged I/Q pair per block to the output FIFOs, honouring Empty/Almost-full flow control.
- Uses the same 128-bit config_reg / 8-bit status_reg register interface as the interpolator core, so both cores share one CSR wrapper and FIFO pair.

---
 rtl/decim_avg_pkg.sv | 40 ++++
 rtl/decim_avg_lane.sv | 59 +++++
 rtl/decim_avg_iq_core.sv | 170 +++++++++++++++++
 tb/tb_decim_avg_iq_core.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decim_avg_pkg.sv
// Shared definitions for the I/Q decimating averager and its CSR wrapper.
// Holds the FSM state encoding, config_reg field offsets, status_reg bit
// indices and the effective decimation-exponent helper.
package decim_avg_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_ACC  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // config_reg field offsets
    localparam int unsigned CFG_BYPASS_BIT = 0;
    localparam int unsigned CFG_LOG2D_LSB  = 32;
    localparam int unsigned CFG_LOG2D_MSB  = 35;
    localparam int unsigned CFG_LEN_LSB    = 96;

    // status_reg bit indices (shared with the interpolator CSR wrapper)
    localparam int unsigned ST_DONE       = 0;
    localparam int unsigned ST_BUSY       = 1;
    localparam int unsigned ST_STOP_EMPTY = 2;
    localparam int unsigned ST_STOP_AFULL = 3;
    localparam int unsigned ST_BYPASS     = 5;

    // Bypass forces D = 1; otherwise the requested exponent is clamped.
    function automatic int unsigned eff_log2d(input logic        bypass,
                                              input logic [3:0]  log2d,
                                              input int unsigned max_log2d);
        int unsigned req;
        req = {28'd0, log2d};
        if (bypass)
            return 0;
        if (req > max_log2d)
            return max_log2d;
        return req;
    endfunction

endpackage

// File: rtl/decim_avg_lane.sv
// One datapath lane of the decimating averager.
// Accumulates sign-extended samples and, on the last sample of a block,
// registers (acc + din) >>> shamt as the decimated output.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        clear the accumulator (run start)
//   acc_en     a FIFO sample is present on din this cycle
//   last       din is the final sample of the current block
//   shamt      effective log2 of the decimation factor
//   din        input sample (signed)
//   dout       registered decimated sample
module decim_avg_lane
    import decim_avg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LOG2_D_MAX  = 4,
    parameter int unsigned SHIFT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   acc_en,
    input  logic                   last,
    input  logic [SHIFT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout
);

    localparam int unsigned ACC_WIDTH = DATA_WIDTH + LOG2_D_MAX;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] din_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic        [DATA_WIDTH-1:0] avg;

    always_comb begin
        din_ext = {{LOG2_D_MAX{din[DATA_WIDTH-1]}}, din};
        sum     = acc + din_ext;
        // The quotient of a block average always fits back in DATA_WIDTH.
        avg     = DATA_WIDTH'(sum >>> shamt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            dout <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            if (last) begin
                acc  <= '0;
                dout <= avg;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/decim_avg_iq_core.sv
// Decimating I/Q averager core.
// Pops paired I/Q samples from the input FIFOs, averages each block of
// D = 2^eD samples per lane and pushes one averaged pair per block to the
// output FIFOs, honouring Empty_i / Afull_i flow control.
// Ports:
//   clk, rstn            clock and synchronous active-high reset
//   start                run request (accepted in S_IDLE / S_DONE)
//   Empty_i, Afull_i     input FIFO empty, output FIFO almost full
//   config_reg           [0] bypass, [35:32] log2D, [96 +: LEN_WIDTH] olen
//   data_in_from_fifo_*  I/Q samples, valid the cycle after Read_Enable_fifo
//   Read_Enable_fifo     pop both input FIFOs
//   Write_Enable_fifo    push I_dec/Q_dec
//   status_reg           done, busy, stop_empty, stop_Afull, bypass
//   I_dec, Q_dec         registered decimated outputs
module decim_avg_iq_core
    import decim_avg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOG2_D_MAX = 4,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  Empty_i,
    input  logic                  Afull_i,
    input  logic [127:0]          config_reg,
    input  logic [DATA_WIDTH-1:0] data_in_from_fifo_I,
    input  logic [DATA_WIDTH-1:0] data_in_from_fifo_Q,
    output logic                  Read_Enable_fifo,
    output logic                  Write_Enable_fifo,
    output logic [7:0]            status_reg,
    output logic [DATA_WIDTH-1:0] I_dec,
    output logic [DATA_WIDTH-1:0] Q_dec
);

    localparam int unsigned SHW = $clog2(LOG2_D_MAX + 1);

    state_t                state;
    logic [LOG2_D_MAX-1:0] sample_cnt;
    logic [LOG2_D_MAX-1:0] d_minus_1;
    logic [LEN_WIDTH-1:0]  out_cnt;
    logic [LEN_WIDTH-1:0]  olen_q;
    logic [LEN_WIDTH-1:0]  olen_last;
    logic [SHW-1:0]        ed_q;
    logic                  bypass_q;
    logic                  stop_empty;
    logic                  stop_afull;

    logic                  cfg_bypass;
    logic [3:0]            cfg_log2d;
    logic [LEN_WIDTH-1:0]  cfg_olen;
    logic                  start_ok;
    logic                  acc_en;
    logic                  last;
    logic                  unused_cfg;

    always_comb begin
        cfg_bypass = config_reg[CFG_BYPASS_BIT];
        cfg_log2d  = config_reg[CFG_LOG2D_MSB:CFG_LOG2D_LSB];
        cfg_olen   = config_reg[CFG_LEN_LSB +: LEN_WIDTH];
        start_ok   = start && (state == S_IDLE || state == S_DONE);
        d_minus_1  = LOG2_D_MAX'((32'd1 << ed_q) - 32'd1);
        olen_last  = olen_q - LEN_WIDTH'(1);
        acc_en     = (state == S_ACC);
        last       = (sample_cnt == d_minus_1);
    end

    assign unused_cfg = &{1'b0,
                          config_reg[CFG_LOG2D_LSB-1:CFG_BYPASS_BIT+1],
                          config_reg[CFG_LEN_LSB-1:CFG_LOG2D_MSB+1],
                          config_reg[127:CFG_LEN_LSB+LEN_WIDTH]};

    always_ff @(posedge clk) begin
        if (rstn) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            out_cnt    <= '0;
            olen_q     <= '0;
            ed_q       <= '0;
            bypass_q   <= 1'b0;
            stop_empty <= 1'b0;
            stop_afull <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        olen_q     <= cfg_olen;
                        ed_q       <= SHW'(eff_log2d(cfg_bypass, cfg_log2d, LOG2_D_MAX));
                        bypass_q   <= cfg_bypass;
                        sample_cnt <= '0;
                        out_cnt    <= '0;
                        stop_empty <= 1'b0;
                        stop_afull <= 1'b0;
                        state      <= (cfg_olen == '0) ? S_DONE : S_RD;
                    end
                end
                S_RD: begin
                    if (Empty_i) begin
                        stop_empty <= 1'b1;
                    end else begin
                        stop_empty <= 1'b0;
                        state      <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (last) begin
                        sample_cnt <= '0;
                        state      <= S_WR;
                    end else begin
                        sample_cnt <= sample_cnt + LOG2_D_MAX'(1);
                        state      <= S_RD;
                    end
                end
                S_WR: begin
                    if (Afull_i) begin
                        stop_afull <= 1'b1;
                    end else begin
                        stop_afull <= 1'b0;
                        out_cnt    <= out_cnt + LEN_WIDTH'(1);
                        state      <= (out_cnt == olen_last) ? S_DONE : S_RD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Read_Enable_fifo  = (state == S_RD) && !Empty_i;
        Write_Enable_fifo = (state == S_WR) && !Afull_i;
        status_reg                = '0;
        status_reg[ST_DONE]       = (state == S_DONE);
        status_reg[ST_BUSY]       = (state == S_RD) || (state == S_ACC) || (state == S_WR);
        status_reg[ST_STOP_EMPTY] = stop_empty;
        status_reg[ST_STOP_AFULL] = stop_afull;
        status_reg[ST_BYPASS]     = bypass_q;
    end

    decim_avg_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_D_MAX (LOG2_D_MAX),
        .SHIFT_WIDTH(SHW)
    ) u_lane_i (
        .clk   (clk),
        .rst   (rstn),
        .clr   (start_ok),
        .acc_en(acc_en),
        .last  (last),
        .shamt (ed_q),
        .din   (data_in_from_fifo_I),
        .dout  (I_dec)
    );

    decim_avg_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_D_MAX (LOG2_D_MAX),
        .SHIFT_WIDTH(SHW)
    ) u_lane_q (
        .clk   (clk),
        .rst   (rstn),
        .clr   (start_ok),
        .acc_en(acc_en),
        .last  (last),
        .shamt (ed_q),
        .din   (data_in_from_fifo_Q),
        .dout  (Q_dec)
    );

endmodule

// File: tb/tb_decim_avg_iq_core.sv
module tb_decim_avg_iq_core;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          Empty_i;
    logic          Afull_i;
    logic [127:0]  config_reg;
    logic [DW-1:0] data_I = '0;
    logic [DW-1:0] data_Q = '0;
    logic          Read_Enable_fifo;
    logic          Write_Enable_fifo;
    logic [7:0]    status_reg;
    logic [DW-1:0] I_dec;
    logic [DW-1:0] Q_dec;

    decim_avg_iq_core #(
        .DATA_WIDTH(DW),
        .LOG2_D_MAX(4),
        .LEN_WIDTH (8)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .start              (start),
        .Empty_i            (Empty_i),
        .Afull_i            (Afull_i),
        .config_reg         (config_reg),
        .data_in_from_fifo_I(data_I),
        .data_in_from_fifo_Q(data_Q),
        .Read_Enable_fifo   (Read_Enable_fifo),
        .Write_Enable_fifo  (Write_Enable_fifo),
        .status_reg         (status_reg),
        .I_dec              (I_dec),
        .Q_dec              (Q_dec)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Input FIFO contents / output FIFO log (main process writes fifo_*/bases,
    // the FIFO model process writes counts and the log).
    logic [DW-1:0] fifo_i [64];
    logic [DW-1:0] fifo_q [64];
    logic [DW-1:0] wr_i   [64];
    logic [DW-1:0] wr_q   [64];
    int rd_count = 0;
    int rd_base  = 0;
    int wr_count = 0;
    int wr_base  = 0;

    // FIFO model: popped data appears in the cycle after Read_Enable_fifo.
    always @(negedge clk) begin
        if (Read_Enable_fifo) begin
            data_I   = fifo_i[(rd_count - rd_base) & 63];
            data_Q   = fifo_q[(rd_count - rd_base) & 63];
            rd_count = rd_count + 1;
        end
        if (Write_Enable_fifo) begin
            wr_i[wr_count & 63] = I_dec;
            wr_q[wr_count & 63] = Q_dec;
            wr_count = wr_count + 1;
        end
    end

    typedef struct {
        string      name;
        logic       bypass;
        logic [3:0] log2d;
        logic [7:0] olen;
        int         n_in;
        logic [31:0] in_i [32];
        logic [31:0] in_q [32];
        int         n_out;
        logic [31:0] exp_i [4];
        logic [31:0] exp_q [4];
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after a rising edge; config is scrambled after the start
    // cycle so a core that fails to latch it produces wrong results.
    task automatic run_start(input logic bypass, input logic [3:0] log2d, input logic [7:0] olen);
        config_reg         = '0;
        config_reg[0]      = bypass;
        config_reg[35:32]  = log2d;
        config_reg[96 +: 8] = olen;
        start = 1'b1;
        tick();
        start = 1'b0;
        config_reg = '1;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (status_reg[0]) break;
            tick();
        end
        chk({name, "_done"}, {63'd0, status_reg[0]}, 64'd1);
    endtask

    task automatic wait_rd(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rd_count - rd_base >= n) break;
            tick();
        end
        chk({name, "_rd_reached"}, 64'(rd_count - rd_base >= n), 64'd1);
    endtask

    task automatic new_run();
        rd_base = rd_count;
        wr_base = wr_count;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b1; start = 1'b0; Empty_i = 1'b0; Afull_i = 1'b0; config_reg = '0;

        // vec 0: D=4 average, floor on negative
        vecs[0].name = "avg4"; vecs[0].bypass = 1'b0; vecs[0].log2d = 4'd2; vecs[0].olen = 8'd1;
        vecs[0].n_in = 4; vecs[0].n_out = 1;
        for (int i = 0; i < 4; i++) begin
            vecs[0].in_i[i] = 32'(i + 1);
            vecs[0].in_q[i] = 32'(-(i + 1));
        end
        vecs[0].exp_i[0] = 32'd2;
        vecs[0].exp_q[0] = 32'hFFFF_FFFD;

        // vec 1: D=16 at both full-scale extremes, two blocks
        vecs[1].name = "fullscale16"; vecs[1].bypass = 1'b0; vecs[1].log2d = 4'd4; vecs[1].olen = 8'd2;
        vecs[1].n_in = 32; vecs[1].n_out = 2;
        for (int i = 0; i < 32; i++) begin
            vecs[1].in_i[i] = 32'h7FFF_FFFF;
            vecs[1].in_q[i] = 32'h8000_0000;
        end
        for (int i = 0; i < 2; i++) begin
            vecs[1].exp_i[i] = 32'h7FFF_FFFF;
            vecs[1].exp_q[i] = 32'h8000_0000;
        end

        // vec 2: bypass overrides log2D=3
        vecs[2].name = "bypass"; vecs[2].bypass = 1'b1; vecs[2].log2d = 4'd3; vecs[2].olen = 8'd3;
        vecs[2].n_in = 3; vecs[2].n_out = 3;
        vecs[2].in_i[0] = 32'd5;  vecs[2].in_i[1] = 32'hFFFF_FFF9; vecs[2].in_i[2] = 32'd9;
        vecs[2].in_q[0] = 32'hFFFF_FFFB; vecs[2].in_q[1] = 32'd7; vecs[2].in_q[2] = 32'hFFFF_FFF7;
        for (int i = 0; i < 3; i++) begin
            vecs[2].exp_i[i] = vecs[2].in_i[i];
            vecs[2].exp_q[i] = vecs[2].in_q[i];
        end

        // reset state
        tick(); tick(); tick();
        chk("reset_status", {56'd0, status_reg}, 64'd0);
        rstn = 1'b0;
        tick();
        chk("idle_status", {56'd0, status_reg}, 64'd0);
        chk("idle_rd_en", {63'd0, Read_Enable_fifo}, 64'd0);
        chk("idle_wr_en", {63'd0, Write_Enable_fifo}, 64'd0);
        chk("idle_I_dec", {32'd0, I_dec}, 64'd0);

        // table-driven runs
        for (int v = 0; v < 3; v++) begin
            new_run();
            for (int i = 0; i < vecs[v].n_in; i++) begin
                fifo_i[i] = vecs[v].in_i[i];
                fifo_q[i] = vecs[v].in_q[i];
            end
            run_start(vecs[v].bypass, vecs[v].log2d, vecs[v].olen);
            chk({vecs[v].name, "_busy"}, {63'd0, status_reg[1]}, 64'd1);
            wait_done(vecs[v].name, 400);
            chk({vecs[v].name, "_busy_end"}, {63'd0, status_reg[1]}, 64'd0);
            chk({vecs[v].name, "_bypass_bit"}, {63'd0, status_reg[5]}, {63'd0, vecs[v].bypass});
            chk({vecs[v].name, "_reads"}, 64'(rd_count - rd_base), 64'(vecs[v].n_in));
            chk({vecs[v].name, "_writes"}, 64'(wr_count - wr_base), 64'(vecs[v].n_out));
            for (int k = 0; k < vecs[v].n_out; k++) begin
                chk($sformatf("%s_I%0d", vecs[v].name, k), {32'd0, wr_i[(wr_base + k) & 63]}, {32'd0, vecs[v].exp_i[k]});
                chk($sformatf("%s_Q%0d", vecs[v].name, k), {32'd0, wr_q[(wr_base + k) & 63]}, {32'd0, vecs[v].exp_q[k]});
            end
        end

        // Empty_i stall mid-block: 6,9 -> 7 ; -6,-9 -> -8
        new_run();
        fifo_i[0] = 32'd6; fifo_i[1] = 32'd9;
        fifo_q[0] = 32'hFFFF_FFFA; fifo_q[1] = 32'hFFFF_FFF7;
        run_start(1'b0, 4'd1, 8'd1);
        wait_rd("empty", 1, 20);
        Empty_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("empty_rd_en%0d", k), {63'd0, Read_Enable_fifo}, 64'd0);
            if (k >= 1)
                chk($sformatf("empty_stop%0d", k), {63'd0, status_reg[2]}, 64'd1);
        end
        chk("empty_no_pop", 64'(rd_count - rd_base), 64'd1);
        Empty_i = 1'b0;
        tick();
        chk("empty_stop_clear", {63'd0, status_reg[2]}, 64'd0);
        wait_done("empty", 50);
        chk("empty_writes", 64'(wr_count - wr_base), 64'd1);
        chk("empty_I", {32'd0, wr_i[wr_base & 63]}, 64'd7);
        chk("empty_Q", {32'd0, wr_q[wr_base & 63]}, 64'hFFFF_FFF8);

        // Afull_i stall in S_WR: 10,20 -> 15 ; 1,2 -> 1
        new_run();
        fifo_i[0] = 32'd10; fifo_i[1] = 32'd20;
        fifo_q[0] = 32'd1;  fifo_q[1] = 32'd2;
        Afull_i = 1'b1;
        run_start(1'b0, 4'd1, 8'd1);
        for (int i = 0; i < 30; i++) begin
            if (status_reg[3]) break;
            tick();
        end
        chk("afull_stop", {63'd0, status_reg[3]}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("afull_wr_en%0d", k), {63'd0, Write_Enable_fifo}, 64'd0);
            chk($sformatf("afull_I_hold%0d", k), {32'd0, I_dec}, 64'd15);
        end
        chk("afull_no_write", 64'(wr_count - wr_base), 64'd0);
        Afull_i = 1'b0;
        wait_done("afull", 20);
        tick(); tick();
        chk("afull_writes", 64'(wr_count - wr_base), 64'd1);
        chk("afull_I", {32'd0, wr_i[wr_base & 63]}, 64'd15);
        chk("afull_Q", {32'd0, wr_q[wr_base & 63]}, 64'd1);
        chk("afull_stop_clear", {63'd0, status_reg[3]}, 64'd0);

        // olen = 0: done right after start, no traffic
        new_run();
        run_start(1'b0, 4'd2, 8'd0);
        chk("olen0_done", {63'd0, status_reg[0]}, 64'd1);
        chk("olen0_busy", {63'd0, status_reg[1]}, 64'd0);
        tick(); tick(); tick();
        chk("olen0_reads", 64'(rd_count - rd_base), 64'd0);
        chk("olen0_writes", 64'(wr_count - wr_base), 64'd0);

        // reset while accumulating, then a clean run
        new_run();
        for (int i = 0; i < 4; i++) begin
            fifo_i[i] = 32'(100 * (i + 1));
            fifo_q[i] = 32'(100 * (i + 1));
        end
        run_start(1'b0, 4'd2, 8'd1);
        wait_rd("rst", 2, 20);
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        chk("rst_status", {56'd0, status_reg}, 64'd0);
        chk("rst_I_dec", {32'd0, I_dec}, 64'd0);
        chk("rst_Q_dec", {32'd0, Q_dec}, 64'd0);
        chk("rst_rd_en", {63'd0, Read_Enable_fifo}, 64'd0);
        chk("rst_wr_en", {63'd0, Write_Enable_fifo}, 64'd0);
        tick(); tick();
        chk("rst_reads", 64'(rd_count - rd_base), 64'd2);

        new_run();
        fifo_i[0] = 32'd8; fifo_i[1] = 32'd8; fifo_i[2] = 32'd8; fifo_i[3] = 32'd12;
        fifo_q[0] = 32'hFFFF_FFFF; fifo_q[1] = 32'd0; fifo_q[2] = 32'd0; fifo_q[3] = 32'd0;
        run_start(1'b0, 4'd2, 8'd1);
        wait_done("post_rst", 50);
        chk("post_rst_writes", 64'(wr_count - wr_base), 64'd1);
        chk("post_rst_I", {32'd0, wr_i[wr_base & 63]}, 64'd9);
        chk("post_rst_Q", {32'd0, wr_q[wr_base & 63]}, 64'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
